i2cs_reg_arbiter: RTL and testbench
===================================

Name: i2cs_reg_arbiter

Overview:
- Shares the single I2C-slave register-file access port between two requesters.
- Requester 0 is the APB slave interface; requester 1 is the I2C-side protocol engine.
- Sequences each access as strobe, wait, acknowledge, and returns read data to the granted requester.
- Resolves simultaneous requests round-robin by default, or by fixed priority when the optional feature is compiled in.

Parameters:
- ADDR_W, 12, register address width.
- DATA_W, 32, register data width.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- apb_pclk_i  input  1  single clock; all logic on rising edge.
- apb_preset_i  input  1  reset, synchronous, active-high.
- req0_i  input  1  requester 0 (APB) access request.
- we0_i  input  1  requester 0: 1 = write, 0 = read.
- addr0_i  input  ADDR_W  requester 0 address.
- wdata0_i  input  DATA_W  requester 0 write data.
- ack0_o  output  1  requester 0 completion pulse.
- rdata0_o  output  DATA_W  requester 0 read data, valid while ack0_o=1.
- req1_i, we1_i, addr1_i, wdata1_i, ack1_o, rdata1_o: same widths and meaning for requester 1 (I2C side).
- reg_addr_o  output  ADDR_W  shared register-port address.
- reg_wdata_o  output  DATA_W  shared register-port write data.
- reg_wr_o  output  1  register write strobe, one cycle.
- reg_rd_o  output  1  register read strobe, one cycle.
- reg_rdata_i  input  DATA_W  register read data, valid the cycle after reg_rd_o.
- busy_o  output  1  high whenever the FSM is not IDLE.
- gnt_id_o  output  1  id of the current or most recent grant.
- conflict_cnt_o  output  CNT_W  saturating count of cycles in which both requests were arbitrated simultaneously.

Behaviour:
- Reset values: every output is 0, except gnt_id_o = 1.
  - Internal state: FSM = IDLE; last-served pointer = 1, so requester 0 wins the first tie; data capture registers cleared.
- FSM states are IDLE, ACCESS, WAIT, ACK. All outputs are registers or decodes of registered state.
- IDLE:
  - No request: remain in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester that was not last served (round-robin) and increment conflict_cnt_o, saturating at all-ones with no wrap.
  - On any grant: latch gnt_id, we, addr and wdata of the winner; go to ACCESS.
- ACCESS (1 cycle):
  - reg_addr_o and reg_wdata_o are driven from the latched values.
  - Exactly one of reg_wr_o or reg_rd_o is high, selected by the latched we.
  - Go to WAIT.
- WAIT (1 cycle):
  - All strobes low.
  - For a read, capture reg_rdata_i into the rdata register of the granted requester. The other requester's rdata register is unchanged.
  - For a write, leave rdata registers unchanged.
  - Go to ACK.
- ACK (1 cycle):
  - ack<gnt>_o = 1; the captured rdata is stable.
  - Update the last-served pointer to gnt_id.
  - Go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle N: strobe in N+1, ack in N+3.
  - Minimum spacing between grants is 4 cycles.
- Requester handshake rules:
  - Hold req, we, addr and wdata stable from assertion until ack.
  - Deassert req, or present a new request, in the cycle after ack. A req still high in IDLE is treated as a new request.
- A requester that drops req after it has been granted:
  - The access still completes.
  - Its ack still pulses.
- The losing requester waits in IDLE with req held. It is granted at the next IDLE, so waiting is bounded at 4 cycles.
- The address and data outputs to the register port hold their last values outside ACCESS. The strobes are the only qualifiers.
- rdataN_o holds its last captured value between acks.
- Reset asserted mid-transaction:
  - FSM returns to IDLE on the next edge.
  - Strobes and acks go low.
  - Any in-flight access is abandoned without an ack.

Optional Feature:
- Macro: I2CS_ARB_FIXED_PRIO_EN.
- Defined:
  - Requester 1 (I2C) always wins a tie; the last-served pointer is ignored.
  - conflict_cnt_o still counts ties.
- Undefined: round-robin as specified above.

Test Plan:
- Write 0x5A5A_0001 to 0x010 via req0 only: reg_wr_o pulses at N+1 with that address and data; ack0_o pulses at N+3; ack1_o stays 0.
- Read 0x020 via req1 with reg_rdata_i=0xCAFE_F00D in the WAIT cycle: reg_rd_o pulses at N+1; ack1_o pulses at N+3 with rdata1_o=0xCAFE_F00D; rdata0_o unchanged.
- Both requesting from reset, reads to 0x004 (req0) and 0x008 (req1): req0 is served first and req1 second, with the strobes 4 cycles apart; conflict_cnt_o=1 after the first arbitration; gnt_id_o = 0 during the first transaction and 1 during the second.
- Both requesting continuously for 600 transactions: grants alternate 0,1,0,1 throughout; conflict_cnt_o saturates at 0xFF and does not wrap.
- Reset asserted during WAIT of a read: no ack pulses; busy_o=0 and strobes=0 on the next edge; a new req0 afterwards completes normally.
- With I2CS_ARB_FIXED_PRIO_EN defined and both requesting continuously: req1 is granted every time; req0 is granted only after req1 deasserts.

Source files
------------

// File: rtl/i2cs_reg_arbiter.sv
// Two-requester arbiter for the I2C-slave register-file port: APB (req0) and I2C engine (req1).
// Round-robin on ties; define I2CS_ARB_FIXED_PRIO_EN to make requester 1 always win a tie.
module i2cs_reg_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              apb_pclk_i,
    input  logic              apb_preset_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              ack0_o,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_wr_o,
    output logic              reg_rd_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              busy_o,
    output logic              gnt_id_o,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_gnt_id;
    logic              r_last;
    logic              r_we;
    logic              r_wr;
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [CNT_W-1:0]  r_conflict;

    logic w_tie;
    logic w_any;
    logic w_winner;
    logic w_win_we;

    assign w_tie = req0_i & req1_i;
    assign w_any = req0_i | req1_i;

`ifdef I2CS_ARB_FIXED_PRIO_EN
    assign w_winner = w_tie ? 1'b1 : req1_i;
`else
    assign w_winner = w_tie ? ~r_last : req1_i;
`endif

    assign w_win_we = w_winner ? we1_i : we0_i;

    always_ff @(posedge apb_pclk_i) begin
        // NOTE: every register here uses <= so all state advances together on the edge.
        if (apb_preset_i) begin
            // NOTE: the capture registers are reset too; they are a handful of flops, not a memory array.
            r_state    <= ST_IDLE;
            r_gnt_id   <= 1'b1;
            r_last     <= 1'b1;
            r_we       <= 1'b0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_conflict <= '0;
        end else begin
            r_wr <= 1'b0;
            r_rd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt_id <= w_winner;
                        r_we     <= w_win_we;
                        r_addr   <= w_winner ? addr1_i : addr0_i;
                        r_wdata  <= w_winner ? wdata1_i : wdata0_i;
                        r_wr     <= w_win_we;
                        r_rd     <= ~w_win_we;
                        if (w_tie && !(&r_conflict)) begin
                            r_conflict <= r_conflict + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: r_state <= ST_WAIT;
                ST_WAIT: begin
                    // Register file returns read data one cycle after the strobe.
                    if (!r_we) begin
                        if (r_gnt_id) r_rdata1 <= reg_rdata_i;
                        else          r_rdata0 <= reg_rdata_i;
                    end
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_last  <= r_gnt_id;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ack0_o         = (r_state == ST_ACK) & ~r_gnt_id;
    assign ack1_o         = (r_state == ST_ACK) &  r_gnt_id;
    assign rdata0_o       = r_rdata0;
    assign rdata1_o       = r_rdata1;
    assign reg_addr_o     = r_addr;
    assign reg_wdata_o    = r_wdata;
    assign reg_wr_o       = r_wr;
    assign reg_rd_o       = r_rd;
    assign busy_o         = (r_state != ST_IDLE);
    assign gnt_id_o       = r_gnt_id;
    assign conflict_cnt_o = r_conflict;

endmodule

// File: tb/tb_i2cs_reg_arbiter.sv
// Self-checking bench for i2cs_reg_arbiter: table-driven vectors plus a strobe/ack scoreboard.
module tb_i2cs_reg_arbiter;

`ifdef I2CS_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_i, we0_i, req1_i, we1_i;
    logic [11:0] addr0_i, addr1_i;
    logic [31:0] wdata0_i, wdata1_i;
    logic        ack0_o, ack1_o;
    logic [31:0] rdata0_o, rdata1_o;
    logic [11:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_wr_o, reg_rd_o;
    logic [31:0] reg_rdata_i;
    logic        busy_o, gnt_id_o;
    logic [7:0]  conflict_cnt_o;

    i2cs_reg_arbiter dut (
        .apb_pclk_i     (clk),
        .apb_preset_i   (rst),
        .req0_i         (req0_i),
        .we0_i          (we0_i),
        .addr0_i        (addr0_i),
        .wdata0_i       (wdata0_i),
        .ack0_o         (ack0_o),
        .rdata0_o       (rdata0_o),
        .req1_i         (req1_i),
        .we1_i          (we1_i),
        .addr1_i        (addr1_i),
        .wdata1_i       (wdata1_i),
        .ack1_o         (ack1_o),
        .rdata1_o       (rdata1_o),
        .reg_addr_o     (reg_addr_o),
        .reg_wdata_o    (reg_wdata_o),
        .reg_wr_o       (reg_wr_o),
        .reg_rd_o       (reg_rd_o),
        .reg_rdata_i    (reg_rdata_i),
        .busy_o         (busy_o),
        .gnt_id_o       (gnt_id_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          id;
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  cnt;
        bit          b2b;
        int          t_req;
    } exp_t;

    typedef struct {
        bit          r0;
        bit          r1;
        bit          we0;
        bit          we1;
        logic [11:0] a0;
        logic [11:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          first;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[7];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          m_last = 1'b1;
    logic [7:0]  m_cnt = 8'h00;
    logic [31:0] exp_rd0 = '0;
    logic [31:0] exp_rd1 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every strobe and ack against the head of the scoreboard
    // and plays the register file, returning the expected read data only in WAIT.
    bit          pending = 1'b0;
    logic [31:0] pend_val;
    int          mon_strobe = -100;
    exp_t        me;

    always @(negedge clk) begin
        if (rst) begin
            pending    = 1'b0;
            mon_strobe = -100;
        end else begin
            if (pending) begin
                reg_rdata_i = pend_val;
                pending     = 1'b0;
            end else begin
                reg_rdata_i = 32'h0BAD_0000 ^ 32'(cyc);
            end
            if (reg_wr_o || reg_rd_o) begin
                if (sb.size() == 0) check("strobe_unexpected", 1, 0);
                else begin
                    me = sb[0];
                    check("strobe_onehot", reg_wr_o & reg_rd_o, 0);
                    check("strobe_busy", busy_o, 1);
                    check("strobe_gnt", gnt_id_o, me.id);
                    check("strobe_we", reg_wr_o, me.we);
                    check("strobe_addr", reg_addr_o, me.addr);
                    if (me.we) check("strobe_wdata", reg_wdata_o, me.wdata);
                    check("conflict_cnt", conflict_cnt_o, me.cnt);
                    if (me.t_req >= 0) check("req_to_strobe", cyc, me.t_req + 1);
                    if (me.b2b) check("strobe_spacing", cyc - mon_strobe, 4);
                    mon_strobe = cyc;
                    if (!me.we) begin
                        pending  = 1'b1;
                        pend_val = me.rdata;
                    end
                end
            end
            if (ack0_o || ack1_o) begin
                if (sb.size() == 0) check("ack_unexpected", {ack1_o, ack0_o}, 0);
                else begin
                    me = sb.pop_front();
                    check("ack_id", {ack1_o, ack0_o}, me.id ? 2'b10 : 2'b01);
                    check("ack_latency", cyc - mon_strobe, 2);
                    check("ack_gnt", gnt_id_o, me.id);
                    if (!me.we) begin
                        if (me.id) exp_rd1 = me.rdata;
                        else       exp_rd0 = me.rdata;
                    end
                    check("rdata0", rdata0_o, exp_rd0);
                    check("rdata1", rdata1_o, exp_rd1);
                end
            end
        end
    end

    function automatic exp_t mk(input bit id, input vec_t v, input int t, input bit b2b);
        exp_t e;
        e.id    = id;
        e.we    = id ? v.we1 : v.we0;
        e.addr  = id ? v.a1 : v.a0;
        e.wdata = id ? v.d1 : v.d0;
        e.rdata = id ? v.d1 : v.d0;
        e.cnt   = m_cnt;
        e.b2b   = b2b;
        e.t_req = t;
        return e;
    endfunction

    task automatic wait_ack(input bit id);
        bit got = 1'b0;
        for (int k = 0; k < 32 && !got; k++) begin
            @(negedge clk);
            got = id ? ack1_o : ack0_o;
        end
        check(id ? "ack1_timeout" : "ack0_timeout", got, 1);
    endtask

    task automatic drop(input bit id);
        if (id) req1_i = 1'b0;
        else    req0_i = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        bit tie = v.r0 && v.r1;
        bit f   = tie ? (FIXED ? 1'b1 : v.first) : v.r1;
        int t;
        @(negedge clk);
        t = cyc;
        if (tie && m_cnt != 8'hFF) m_cnt++;
        sb.push_back(mk(f, v, t, 1'b0));
        if (tie) sb.push_back(mk(~f, v, -1, 1'b1));
        req0_i = v.r0; we0_i = v.we0; addr0_i = v.a0; wdata0_i = v.d0;
        req1_i = v.r1; we1_i = v.we1; addr1_i = v.a1; wdata1_i = v.d1;
        wait_ack(f);
        drop(f);
        if (tie) begin
            wait_ack(~f);
            drop(~f);
        end
        m_last = tie ? ~f : f;
    endtask

    task automatic run_continuous(input int n);
        bit   ids[$];
        bit   ptr = m_last;
        bit   id;
        exp_t e;
        int   t;
        @(negedge clk);
        t = cyc;
        for (int k = 0; k < n; k++) begin
            id = FIXED ? 1'b1 : ~ptr;
            if (m_cnt != 8'hFF) m_cnt++;
            e.id = id; e.we = 1'b0; e.addr = id ? 12'h0A8 : 12'h0A4; e.wdata = '0;
            e.rdata = {id ? 16'h1111 : 16'h2222, 16'(k)};
            e.cnt = m_cnt; e.b2b = (k > 0); e.t_req = (k == 0) ? t : -1;
            sb.push_back(e);
            ids.push_back(id);
            ptr = id;
        end
        req0_i = 1'b1; we0_i = 1'b0; addr0_i = 12'h0A4; wdata0_i = '0;
        req1_i = 1'b1; we1_i = 1'b0; addr1_i = 12'h0A8; wdata1_i = '0;
        for (int k = 0; k < n; k++) wait_ack(ids[k]);
        // Requester 1 backs off; requester 0 must now be served on its own.
        req1_i = 1'b0;
        e.id = 1'b0; e.addr = 12'h0A4; e.rdata = 32'h0000_FFFF;
        e.cnt = m_cnt; e.b2b = 1'b1; e.t_req = -1;
        sb.push_back(e);
        wait_ack(1'b0);
        req0_i = 1'b0;
        m_last = 1'b0;
        check("conflict_saturated", conflict_cnt_o, 8'hFF);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            r0 r1 we0 we1  a0      a1      d0             d1             first
        vecs[0] = '{1, 1, 0, 0, 12'h004, 12'h008, 32'h0404_0404, 32'h0808_0808, 1'b0};
        vecs[1] = '{1, 0, 1, 0, 12'h010, 12'h000, 32'h5A5A_0001, 32'h0,         1'b0};
        vecs[2] = '{0, 1, 0, 0, 12'h000, 12'h020, 32'h0,         32'hCAFE_F00D, 1'b1};
        vecs[3] = '{1, 1, 1, 0, 12'h100, 12'h200, 32'h1234_5678, 32'h8765_4321, 1'b0};
        vecs[4] = '{1, 0, 0, 0, 12'h044, 12'h000, 32'hA5A5_5A5A, 32'h0,         1'b0};
        vecs[5] = '{1, 1, 0, 1, 12'hFFF, 12'h000, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{0, 1, 0, 1, 12'h000, 12'h7FF, 32'h0,         32'h0000_0001, 1'b1};

        rst = 1'b1;
        req0_i = 0; we0_i = 0; addr0_i = '0; wdata0_i = '0;
        req1_i = 0; we1_i = 0; addr1_i = '0; wdata1_i = '0;
        reg_rdata_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_gnt_id", gnt_id_o, 1);
        check("rst_strobes", {reg_wr_o, reg_rd_o}, 0);
        check("rst_acks", {ack1_o, ack0_o}, 0);
        check("rst_conflict", conflict_cnt_o, 0);
        check("rst_rdata", {rdata1_o, rdata0_o}, 0);
        check("rst_reg_port", {reg_addr_o, reg_wdata_o}, 0);
        rst = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i]);

        run_continuous(600);

        // Reset during the WAIT cycle of a read abandons it without an ack.
        @(negedge clk);
        sb.push_back('{1'b0, 1'b0, 12'h030, 32'h0, 32'h1111_2222, m_cnt, 1'b0, -1});
        req0_i = 1'b1; we0_i = 1'b0; addr0_i = 12'h030;
        for (int k = 0; k < 10 && !reg_rd_o; k++) @(negedge clk);
        check("midrst_strobe_seen", reg_rd_o, 1);
        @(negedge clk);
        rst = 1'b1;
        req0_i = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_busy", busy_o, 0);
        check("midrst_strobes", {reg_wr_o, reg_rd_o}, 0);
        check("midrst_acks", {ack1_o, ack0_o}, 0);
        check("midrst_conflict", conflict_cnt_o, 0);
        check("midrst_gnt_id", gnt_id_o, 1);
        rst = 1'b0;
        m_last = 1'b1; m_cnt = 8'h00; exp_rd0 = '0; exp_rd1 = '0;
        @(negedge clk);
        check("midrst_no_ack", {ack1_o, ack0_o}, 0);
        apply_vec('{1, 0, 0, 0, 12'h030, 12'h000, 32'h3C3C_C3C3, 32'h0, 1'b0});
        apply_vec('{1, 1, 0, 0, 12'h034, 12'h038, 32'h0000_0034, 32'h0000_0038, 1'b1});

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
